// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and flag-bundle layout for the ALU sweep checker
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Flag bundle is a packed vector {out, carry, overflow, sign, zero, parity}; parity sits in bit 0.
  localparam int F_PARITY  = 0;
  localparam int F_ZERO    = 1;
  localparam int F_SIGN    = 2;
  localparam int F_OVF     = 3;
  localparam int F_CARRY   = 4;
  localparam int FLAG_BITS = 5;

  function automatic logic [7:0] mask_above(input logic [7:0] mask, input logic [2:0] cur);
    logic [7:0] m;
    m = mask;
    for (int i = 0; i < 8; i++) begin
      if (i <= int'(cur)) m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic logic [2:0] lowest_op(input logic [7:0] mask);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/alu_golden_model.sv
// rtl/alu_golden_model.sv - combinational reference ALU producing the expected flag bundle
module alu_golden_model
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]           a_i,
  input  logic [W-1:0]           b_i,
  input  logic [2:0]             opt_i,
  output logic [W+FLAG_BITS-1:0] exp_o
);

  logic [W:0]   wide;
  logic [W-1:0] res;
  logic         carry;
  logic         ovf;

  always_comb begin
    wide  = '0;
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (opt_i)
      OP_ADD: begin
        wide  = {1'b0, a_i} + {1'b0, b_i};
        res   = wide[W-1:0];
        carry = wide[W];
        ovf   = (a_i[W-1] == b_i[W-1]) && (res[W-1] != a_i[W-1]);
      end
      OP_SUB: begin
        // The extra bit of a zero-extended subtraction is exactly the unsigned borrow.
        wide  = {1'b0, a_i} - {1'b0, b_i};
        res   = wide[W-1:0];
        carry = wide[W];
        ovf   = (a_i[W-1] != b_i[W-1]) && (res[W-1] != a_i[W-1]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_NOT: res = ~a_i;
      OP_SHL: begin
        res   = {a_i[W-2:0], 1'b0};
        carry = a_i[W-1];
      end
      OP_SHR: begin
        res   = {1'b0, a_i[W-1:1]};
        carry = a_i[0];
      end
      default: res = '0;
    endcase
  end

  always_comb begin
    exp_o                           = '0;
    exp_o[W+FLAG_BITS-1:FLAG_BITS]  = res;
    exp_o[F_CARRY]                  = carry;
    exp_o[F_OVF]                    = ovf;
    exp_o[F_SIGN]                   = res[W-1];
    exp_o[F_ZERO]                   = (res == '0);
    exp_o[F_PARITY]                 = ^res;
  end

endmodule

// File: rtl/alu_sweep_checker.sv
// rtl/alu_sweep_checker.sv - exhaustive opcode/operand sweep of the ALU with latency-aligned checking
module alu_sweep_checker
  import alu_pkg::*;
#(
  parameter int W     = 4,
  parameter int LAT   = 1,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       op_mask,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [2:0]       alu_opt,
  input  logic [W-1:0]     alu_out,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_sign,
  input  logic             alu_zero,
  input  logic             alu_parity,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [W-1:0]     fail_a,
  output logic [W-1:0]     fail_b,
  output logic [2:0]       fail_opt
);

  localparam int BW = W + FLAG_BITS;
  localparam logic [1:0] DRAIN_LAST = 2'((LAT > 0) ? LAT - 1 : 0);

  typedef struct packed {
    logic          vld;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2:0]    opt;
    logic [BW-1:0] exp;
  } slot_t;

  state_e           state_q;
  logic [7:0]       mask_q;
  logic [2:0]       op_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             issuing_q;
  logic             issue_vld_q;
  logic [1:0]       drain_q;
  logic [W-1:0]     alu_a_q;
  logic [W-1:0]     alu_b_q;
  logic [2:0]       alu_opt_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [ERR_W-1:0] err_d;
  logic [W-1:0]     fail_a_q;
  logic [W-1:0]     fail_b_q;
  logic [2:0]       fail_opt_q;

  logic [BW-1:0] exp_now;
  logic [BW-1:0] actual;
  slot_t         slot_in;
  slot_t         slot_chk;
  logic          mismatch;
  logic          first_fail;
  logic          accept;
  logic [7:0]    rest_mask;
  logic [2:0]    first_op;
  logic [2:0]    next_op;

  alu_golden_model #(.W(W)) u_golden (
    .a_i   (alu_a_q),
    .b_i   (alu_b_q),
    .opt_i (alu_opt_q),
    .exp_o (exp_now)
  );

  // Each presented vector carries its own expectation down a LAT-deep pipe to meet the ALU's answer.
  assign slot_in = {issue_vld_q, alu_a_q, alu_b_q, alu_opt_q, exp_now};

  generate
    if (LAT == 0) begin : g_comb
      assign slot_chk = slot_in;
    end else begin : g_pipe
      slot_t pipe_q [LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= slot_in;
          for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end
      assign slot_chk = pipe_q[LAT-1];
    end
  endgenerate

  assign actual     = {alu_out, alu_carry, alu_overflow, alu_sign, alu_zero, alu_parity};
  assign mismatch   = slot_chk.vld && (actual != slot_chk.exp);
  assign first_fail = mismatch && (err_q == '0);
  assign err_d      = (mismatch && !(&err_q)) ? err_q + ERR_W'(1) : err_q;

  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign first_op  = lowest_op(op_mask);
  assign rest_mask = mask_above(mask_q, op_q);
  assign next_op   = lowest_op(rest_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      issuing_q   <= 1'b0;
      issue_vld_q <= 1'b0;
      drain_q     <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_opt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_opt_q  <= '0;
    end else begin
      err_q <= err_d;
      if (first_fail) begin
        fail_a_q   <= slot_chk.a;
        fail_b_q   <= slot_chk.b;
        fail_opt_q <= slot_chk.opt;
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            err_q      <= '0;
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_opt_q <= '0;
            if (op_mask == 8'h00) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q   <= ST_RUN;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              pass_q    <= 1'b0;
              mask_q    <= op_mask;
              op_q      <= first_op;
              a_q       <= '0;
              b_q       <= '0;
              issuing_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (issuing_q) begin
            alu_a_q     <= a_q;
            alu_b_q     <= b_q;
            alu_opt_q   <= op_q;
            issue_vld_q <= 1'b1;
            b_q         <= b_q + 1'b1;
            if (&b_q) begin
              a_q <= a_q + 1'b1;
              if (&a_q) begin
                if (|rest_mask) op_q <= next_op;
                else            issuing_q <= 1'b0;
              end
            end
          end else begin
            issue_vld_q <= 1'b0;
            drain_q     <= '0;
            if (LAT == 0) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_opt   = alu_opt_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_opt  = fail_opt_q;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// tb/tb_alu_sweep_checker.sv - directed bench for alu_sweep_checker at LAT 0/1/3 and a narrow error counter
module tb_alu_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] op_mask;
  logic       fz;
  logic       fc;

  // Instance 0: LAT=1, 1: LAT=0, 2: LAT=3, 3: LAT=1 with ERR_W=4.
  logic        start_s   [4];
  logic [3:0]  alu_a_s   [4];
  logic [3:0]  alu_b_s   [4];
  logic [2:0]  alu_opt_s [4];
  logic [8:0]  res_s     [4];
  logic        busy_s    [4];
  logic        done_s    [4];
  logic        pass_s    [4];
  logic [3:0]  fa_s      [4];
  logic [3:0]  fb_s      [4];
  logic [2:0]  fo_s      [4];
  logic [15:0] err16_s   [3];
  logic [3:0]  err4;

  logic [8:0] now_v [4];
  logic [8:0] d0, d3, p2_0, p2_1, p2_2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_sweep_checker #(.W(4), .LAT(1), .ERR_W(16)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op_mask(op_mask),
    .alu_a(alu_a_s[0]), .alu_b(alu_b_s[0]), .alu_opt(alu_opt_s[0]),
    .alu_out(res_s[0][8:5]), .alu_carry(res_s[0][4]), .alu_overflow(res_s[0][3]),
    .alu_sign(res_s[0][2]), .alu_zero(res_s[0][1]), .alu_parity(res_s[0][0]),
    .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]), .err_count(err16_s[0]),
    .fail_a(fa_s[0]), .fail_b(fb_s[0]), .fail_opt(fo_s[0]));

  alu_sweep_checker #(.W(4), .LAT(0), .ERR_W(16)) u_l0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op_mask(op_mask),
    .alu_a(alu_a_s[1]), .alu_b(alu_b_s[1]), .alu_opt(alu_opt_s[1]),
    .alu_out(res_s[1][8:5]), .alu_carry(res_s[1][4]), .alu_overflow(res_s[1][3]),
    .alu_sign(res_s[1][2]), .alu_zero(res_s[1][1]), .alu_parity(res_s[1][0]),
    .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]), .err_count(err16_s[1]),
    .fail_a(fa_s[1]), .fail_b(fb_s[1]), .fail_opt(fo_s[1]));

  alu_sweep_checker #(.W(4), .LAT(3), .ERR_W(16)) u_l3 (
    .clk(clk), .rst_n(rst_n), .start(start_s[2]), .op_mask(op_mask),
    .alu_a(alu_a_s[2]), .alu_b(alu_b_s[2]), .alu_opt(alu_opt_s[2]),
    .alu_out(res_s[2][8:5]), .alu_carry(res_s[2][4]), .alu_overflow(res_s[2][3]),
    .alu_sign(res_s[2][2]), .alu_zero(res_s[2][1]), .alu_parity(res_s[2][0]),
    .busy(busy_s[2]), .done(done_s[2]), .pass(pass_s[2]), .err_count(err16_s[2]),
    .fail_a(fa_s[2]), .fail_b(fb_s[2]), .fail_opt(fo_s[2]));

  alu_sweep_checker #(.W(4), .LAT(1), .ERR_W(4)) u_e4 (
    .clk(clk), .rst_n(rst_n), .start(start_s[3]), .op_mask(op_mask),
    .alu_a(alu_a_s[3]), .alu_b(alu_b_s[3]), .alu_opt(alu_opt_s[3]),
    .alu_out(res_s[3][8:5]), .alu_carry(res_s[3][4]), .alu_overflow(res_s[3][3]),
    .alu_sign(res_s[3][2]), .alu_zero(res_s[3][1]), .alu_parity(res_s[3][0]),
    .busy(busy_s[3]), .done(done_s[3]), .pass(pass_s[3]), .err_count(err4),
    .fail_a(fa_s[3]), .fail_b(fb_s[3]), .fail_opt(fo_s[3]));

  // Reference ALU in integer arithmetic; result is {out, carry, overflow, sign, zero, parity}.
  function automatic logic [8:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int ia, ib, sa, sb, r;
    logic c, v;
    logic [3:0] o;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    c = 1'b0;
    v = 1'b0;
    r = 0;
    case (op)
      3'd0: begin r = ia + ib; c = (r > 15); v = (sa + sb > 7) || (sa + sb < -8); end
      3'd1: begin r = ia - ib; c = (ia < ib); v = (sa - sb > 7) || (sa - sb < -8); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = 15 - ia;
      3'd6: begin r = ia * 2; c = (ia >= 8); end
      default: begin r = ia / 2; c = (ia % 2) == 1; end
    endcase
    o = 4'(r & 15);
    return {o, c, v, o[3], (o == 4'd0), ^o};
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      now_v[i] = ref_alu(alu_a_s[i], alu_b_s[i], alu_opt_s[i]);
      if (fz) now_v[i][1] = 1'b0;
      if (fc) now_v[i][4] = 1'b1;
    end
  end

  always @(posedge clk) begin
    d0   <= now_v[0];
    d3   <= now_v[3];
    p2_0 <= now_v[2];
    p2_1 <= p2_0;
    p2_2 <= p2_1;
  end

  assign res_s[0] = d0;
  assign res_s[1] = now_v[1];
  assign res_s[2] = p2_2;
  assign res_s[3] = d3;

  function automatic logic [15:0] get_err(input int s);
    return (s == 3) ? {12'd0, err4} : err16_s[s];
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sweep(input int s, input logic [7:0] m, input int extra, input logic [7:0] extra_m,
                       input int budget, output int cyc, output bit bseen, output bit bgap);
    bseen = 1'b0;
    bgap  = 1'b0;
    @(negedge clk);
    op_mask    = m;
    start_s[s] = 1'b1;
    @(posedge clk);
    #1;
    start_s[s] = 1'b0;
    cyc = 0;
    while (!done_s[s] && cyc < budget) begin
      if (cyc == extra) begin
        start_s[s] = 1'b1;
        op_mask    = extra_m;
      end else begin
        start_s[s] = 1'b0;
      end
      if (busy_s[s]) bseen = 1'b1;
      else           bgap  = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    start_s[s] = 1'b0;
    check("done_reached", int'(done_s[s]), 1);
  endtask

  int cyc;
  bit bseen, bgap;

  initial begin
    rst_n   = 1'b0;
    op_mask = 8'h00;
    fz      = 1'b0;
    fc      = 1'b0;
    for (int i = 0; i < 4; i++) start_s[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy_s[0]), 0);
    check("rst_done", int'(done_s[0]), 0);
    check("rst_pass", int'(pass_s[0]), 0);
    check("rst_err", int'(get_err(0)), 0);
    check("rst_err_e4", int'(get_err(3)), 0);
    check("rst_alu_vec", int'({alu_a_s[0], alu_b_s[0], alu_opt_s[0]}), 0);
    check("rst_fail_vec", int'({fa_s[0], fb_s[0], fo_s[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    sweep(0, 8'hFF, -1, 8'h00, 3000, cyc, bseen, bgap);
    check("full_l1_cycles", cyc, 2050);
    check("full_l1_pass", int'(pass_s[0]), 1);
    check("full_l1_err", int'(get_err(0)), 0);
    check("full_l1_busy_end", int'(busy_s[0]), 0);
    check("full_l1_busy_gap", int'(bgap), 0);
    check("full_l1_hold_vec", int'({alu_a_s[0], alu_b_s[0], alu_opt_s[0]}), int'({4'd15, 4'd15, 3'd7}));

    fz = 1'b1;
    sweep(0, 8'h01, -1, 8'h00, 400, cyc, bseen, bgap);
    fz = 1'b0;
    check("zero_cycles", cyc, 258);
    check("zero_err", int'(get_err(0)), 16);
    check("zero_pass", int'(pass_s[0]), 0);
    check("zero_fail_vec", int'({fa_s[0], fb_s[0], fo_s[0]}), 0);

    fc = 1'b1;
    sweep(0, 8'h04, -1, 8'h00, 400, cyc, bseen, bgap);
    check("carry_err", int'(get_err(0)), 256);
    check("carry_fail_vec", int'({fa_s[0], fb_s[0], fo_s[0]}), int'({4'd0, 4'd0, 3'd2}));
    sweep(3, 8'h04, -1, 8'h00, 400, cyc, bseen, bgap);
    fc = 1'b0;
    check("sat_err", int'(get_err(3)), 15);
    check("sat_pass", int'(pass_s[3]), 0);
    check("sat_fail_opt", int'(fo_s[3]), 2);

    fz = 1'b1;
    sweep(0, 8'hA0, -1, 8'h00, 700, cyc, bseen, bgap);
    fz = 1'b0;
    check("skip_cycles", cyc, 514);
    check("skip_err", int'(get_err(0)), 48);
    check("skip_fail_vec", int'({fa_s[0], fb_s[0], fo_s[0]}), int'({4'd15, 4'd0, 3'd5}));

    sweep(0, 8'h00, -1, 8'h00, 10, cyc, bseen, bgap);
    check("empty_cycles", cyc, 0);
    check("empty_busy_seen", int'(bseen), 0);
    check("empty_pass", int'(pass_s[0]), 1);
    check("empty_err", int'(get_err(0)), 0);

    sweep(0, 8'hFF, 100, 8'h01, 3000, cyc, bseen, bgap);
    op_mask = 8'h00;
    check("restart_cycles", cyc, 2050);
    check("restart_pass", int'(pass_s[0]), 1);
    check("restart_busy_gap", int'(bgap), 0);

    fz = 1'b1;
    @(negedge clk);
    op_mask    = 8'hFF;
    start_s[0] = 1'b1;
    @(posedge clk);
    #1;
    start_s[0] = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("abort_pre_busy", int'(busy_s[0]), 1);
    check("abort_pre_err_nz", int'(get_err(0) != 16'd0), 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy_s[0]), 0);
    check("abort_done", int'(done_s[0]), 0);
    check("abort_err", int'(get_err(0)), 0);
    check("abort_alu_vec", int'({alu_a_s[0], alu_b_s[0], alu_opt_s[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    fz    = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", int'(done_s[0]), 0);
    sweep(0, 8'hFF, -1, 8'h00, 3000, cyc, bseen, bgap);
    check("post_abort_cycles", cyc, 2050);
    check("post_abort_pass", int'(pass_s[0]), 1);

    sweep(1, 8'hFF, -1, 8'h00, 3000, cyc, bseen, bgap);
    check("l0_cycles", cyc, 2049);
    check("l0_pass", int'(pass_s[1]), 1);
    check("l0_err", int'(get_err(1)), 0);

    sweep(2, 8'hFF, -1, 8'h00, 3000, cyc, bseen, bgap);
    check("l3_cycles", cyc, 2052);
    check("l3_pass", int'(pass_s[2]), 1);
    check("l3_err", int'(get_err(2)), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
